md_iter_unit: RTL and testbench

MD_ITER_UNIT -- requirements
Module: md_iter_unit

---
 rtl/md_iter_unit.sv | 153 +++++++++++++++
 tb/tb_md_iter_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/md_iter_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add MUL/MADD/MSUB and restoring DIV.
// Latency XLEN+2 edges from accept to done; busy stalls new requests, flush aborts without commit.
module md_iter_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic            is_sign,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);
    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    localparam logic [2:0] OP_MTHI = 3'd1;
    localparam logic [2:0] OP_MTLO = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd4;
    localparam logic [2:0] OP_MADD = 3'd5;
    localparam logic [2:0] OP_MSUB = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     mcand_q;
    logic [2*XLEN-1:0]   acc_q;
    logic                neg_q, neg_rem_q, div0_q;
    logic [XLEN-1:0]     a_q;
    logic [XLEN-1:0]     hi_q, lo_q;
    logic                done_q;

    logic                is_md_op;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_sh;
    logic [XLEN+1:0]     div_diff;
    logic [2*XLEN-1:0]   acc_next;
    logic [2*XLEN-1:0]   prod, hilo, res;
    logic [XLEN-1:0]     quot, rem, fix_hi, fix_lo;

    assign is_md_op = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    assign a_mag    = (is_sign && a[XLEN-1]) ? -a : a;
    assign b_mag    = (is_sign && b[XLEN-1]) ? -b : b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && is_md_op) state_d = S_CALC;
            S_CALC:  if (flush) state_d = S_IDLE;
                     else if (cnt_q == LAST) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = done_q;
        o_hi = hi_q;
        o_lo = lo_q;
    end

    // One radix-2 step: multiplier consumed from acc LSB; dividend shifted out of acc low half.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = {1'b0, div_sh} - {2'b00, mcand_q};
        acc_next = {mul_sum, acc_q[XLEN-1:1]};
        if (op_q == OP_DIV) begin
            if (div_diff[XLEN+1]) acc_next = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            else                  acc_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    always_comb begin
        prod   = neg_q ? -acc_q : acc_q;
        hilo   = {hi_q, lo_q};
        quot   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem    = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        res    = prod;
        case (op_q)
            OP_MADD: res = hilo + prod;
            OP_MSUB: res = hilo - prod;
            default: res = prod;
        endcase
        fix_hi = res[2*XLEN-1:XLEN];
        fix_lo = res[XLEN-1:0];
        if (op_q == OP_DIV) begin
            fix_hi = div0_q ? a_q : rem;
            fix_lo = div0_q ? '1 : quot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            op_q      <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            a_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == S_IDLE) begin
                if (start) begin
                    case (op)
                        OP_MTHI: hi_q <= a;
                        OP_MTLO: lo_q <= a;
                        OP_MUL, OP_DIV, OP_MADD, OP_MSUB: begin
                            op_q      <= op;
                            cnt_q     <= '0;
                            a_q       <= a;
                            div0_q    <= (b == '0);
                            neg_q     <= is_sign && (a[XLEN-1] ^ b[XLEN-1]);
                            neg_rem_q <= is_sign && a[XLEN-1];
                            mcand_q   <= (op == OP_DIV) ? b_mag : a_mag;
                            acc_q     <= {{XLEN{1'b0}}, (op == OP_DIV) ? a_mag : b_mag};
                        end
                        default: ;
                    endcase
                end
            end else if (flush) begin
                cnt_q <= '0;
            end else if (state_q == S_CALC) begin
                acc_q <= acc_next;
                cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            end else begin
                hi_q   <= fix_hi;
                lo_q   <= fix_lo;
                done_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_md_iter_unit.sv
// Directed bench for md_iter_unit (XLEN=32): latency, MUL/DIV/MADD/MSUB results, flush and reset abort.
module tb_md_iter_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        is_sign = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] o_hi, o_lo;

    int n_vec = 0;
    int n_err = 0;
    int edges, bcyc, dcnt;

    md_iter_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .is_sign(is_sign),
        .a(a), .b(b), .flush(flush), .busy(busy), .done(done), .o_hi(o_hi), .o_lo(o_lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for exactly one rising edge; returns 1ns after that edge.
    task automatic issue(input logic [2:0] o, input logic s, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        start = 1'b1; op = o; is_sign = s; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0; a = '0; b = '0;
    endtask

    // Counts edges from the accept edge (counted as 1) to the edge after which done is seen.
    task automatic wait_done(output int e, output int bc);
        e  = 1;
        bc = busy ? 1 : 0;
        while (!done && e < 200) begin
            @(posedge clk); #1;
            e++;
            if (busy) bc++;
        end
    endtask

    task automatic count_done(input int n, output int d);
        d = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done) d++;
        end
    endtask

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", o_hi, 0);
        check("rst_lo", o_lo, 0);
        @(negedge clk); rst_n = 1'b1;

        issue(3'd3, 1'b0, 32'hFFFF_FFFF, 32'd2);
        check("mul_busy_at_accept", busy, 1);
        wait_done(edges, bcyc);
        check("mul_done_edges", edges, 34);
        check("mul_busy_cycles", bcyc, 33);
        check("mul_hi", o_hi, 32'h0000_0001);
        check("mul_lo", o_lo, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        check("mul_done_pulse", done, 0);

        issue(3'd4, 1'b1, -32'sd7, 32'd2);
        wait_done(edges, bcyc);
        check("sdiv_edges", edges, 34);
        check("sdiv_lo", o_lo, 32'hFFFF_FFFD);
        check("sdiv_hi", o_hi, 32'hFFFF_FFFF);

        issue(3'd4, 1'b0, 32'd5, 32'd0);
        wait_done(edges, bcyc);
        check("div0_edges", edges, 34);
        check("div0_lo", o_lo, 32'hFFFF_FFFF);
        check("div0_hi", o_hi, 32'h0000_0005);

        issue(3'd1, 1'b0, 32'd0, 32'd0);
        check("mthi_busy", busy, 0);
        check("mthi_done", done, 0);
        issue(3'd2, 1'b0, 32'd10, 32'd0);
        check("mtlo_lo", o_lo, 32'd10);
        check("mthi_hi", o_hi, 32'd0);

        // 10 + (-3*4) = -2 as a 64-bit value.
        issue(3'd5, 1'b1, -32'sd3, 32'd4);
        wait_done(edges, bcyc);
        check("madd_hi", o_hi, 32'hFFFF_FFFF);
        check("madd_lo", o_lo, 32'hFFFF_FFFE);
        issue(3'd6, 1'b1, 32'd1, 32'd1);
        wait_done(edges, bcyc);
        check("msub_hi", o_hi, 32'hFFFF_FFFF);
        check("msub_lo", o_lo, 32'hFFFF_FFFD);

        issue(3'd4, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(edges, bcyc);
        check("ovf_lo", o_lo, 32'h8000_0000);
        check("ovf_hi", o_hi, 32'h0000_0000);

        issue(3'd3, 1'b1, -32'sd2, 32'd3);
        wait_done(edges, bcyc);
        check("smul_hi", o_hi, 32'hFFFF_FFFF);
        check("smul_lo", o_lo, 32'hFFFF_FFFA);

        issue(3'd1, 1'b0, 32'h1234, 32'd0);
        issue(3'd2, 1'b0, 32'h5678, 32'd0);
        issue(3'd3, 1'b0, 32'd3, 32'd5);
        repeat (3) @(posedge clk);
        issue(3'd2, 1'b0, 32'hDEAD, 32'd0);
        check("busy_mtlo_ignored", o_lo, 32'h5678);
        check("busy_still", busy, 1);
        repeat (5) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_busy", busy, 0);
        count_done(40, dcnt);
        check("flush_no_done", dcnt, 0);
        check("flush_hi", o_hi, 32'h1234);
        check("flush_lo", o_lo, 32'h5678);

        @(negedge clk);
        flush = 1'b1; start = 1'b1; op = 3'd2; a = 32'h77;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0; op = 3'd0; a = '0;
        check("idle_flush_mtlo", o_lo, 32'h77);

        issue(3'd4, 1'b0, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk); #2; rst_n = 1'b0; #1;
        check("arst_hi", o_hi, 0);
        check("arst_lo", o_lo, 0);
        check("arst_busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;
        count_done(40, dcnt);
        check("arst_no_done", dcnt, 0);
        check("arst_hi_after", o_hi, 0);

        issue(3'd3, 1'b0, 32'd6, 32'd7);
        wait_done(edges, bcyc);
        check("post_rst_edges", edges, 34);
        check("post_rst_lo", o_lo, 32'd42);
        check("post_rst_hi", o_hi, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
